// File: rtl/ddr4_mc_ecc_buf_pkg.sv
// Shared sizing helpers and beat/parity functions for the DDR4 MC ECC merge buffer.
// Functions work on fixed maximum widths; callers cast to their own widths.
package ddr4_mc_ecc_buf_pkg;

    localparam int MAX_PAYLOAD_W = 4096;
    localparam int MAX_BEAT_W    = 256;

    function automatic int buf_idx_w(input int addr_bits, input int off_bits);
        return addr_bits + off_bits;
    endfunction

    function automatic int buf_depth(input int addr_bits, input int off_bits);
        return 1 << (addr_bits + off_bits);
    endfunction

    // Low bits of beat 'beat' in a payload of 'payload_w'-bit beats; the ECC bits end up truncated by the caller.
    function automatic logic [MAX_BEAT_W-1:0] beat_extract(input logic [MAX_PAYLOAD_W-1:0] payload,
                                                           input int beat, input int payload_w);
        return MAX_BEAT_W'(payload >> (beat * payload_w));
    endfunction

    function automatic logic even_par(input logic [MAX_BEAT_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ddr4_mc_ecc_buf_ram.sv
// WIDTH x DEPTH distributed RAM: one synchronous write port, one asynchronous read port, no reset.
module ddr4_mc_ecc_buf_ram #(
    parameter int WIDTH  = 512,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ddr4_mc_ecc_merge_buf.sv
// RMW merge buffer: captures ECC-stripped read beats per slot and returns them, registered, for merge.
// Optional per-beat parity protection of the stored data: define DDR4_MC_ECC_BUF_PARITY_EN.
module ddr4_mc_ecc_merge_buf
    import ddr4_mc_ecc_buf_pkg::*;
#(
    parameter int TCQ                   = 100,
    parameter int PAYLOAD_WIDTH         = 72,
    parameter int DATA_WIDTH            = 64,
    parameter int nCK_PER_CLK           = 4,
    parameter int DATA_BUF_ADDR_WIDTH   = 5,
    parameter int DATA_BUF_OFFSET_WIDTH = 1,
    parameter int BUF_ADDR_BITS         = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [2*nCK_PER_CLK*PAYLOAD_WIDTH-1:0]           rd_data,
    input  logic [DATA_BUF_ADDR_WIDTH-1:0]                   rd_data_addr,
    input  logic [DATA_BUF_OFFSET_WIDTH-1:0]                 rd_data_offset,
    input  logic                                             wr_ecc_buf,
    input  logic [DATA_BUF_ADDR_WIDTH-1:0]                   wr_data_addr,
    input  logic [DATA_BUF_OFFSET_WIDTH-1:0]                 wr_data_offset,
    input  logic                                             rd_merge_req,
    input  logic                                             rd_merge_release,
    output logic [2*nCK_PER_CLK*DATA_WIDTH-1:0]              rd_merge_data,
    output logic                                             rd_merge_valid,
    output logic                                             rd_merge_miss,
`ifdef DDR4_MC_ECC_BUF_PARITY_EN
    output logic [2*nCK_PER_CLK-1:0]                         rd_merge_par_err,
`endif
    output logic [BUF_ADDR_BITS+DATA_BUF_OFFSET_WIDTH:0]     buf_occupancy,
    output logic                                             buf_overwrite_err
);

    localparam int BEATS  = 2 * nCK_PER_CLK;
    localparam int IDX_W  = buf_idx_w(BUF_ADDR_BITS, DATA_BUF_OFFSET_WIDTH);
    localparam int DEPTH  = buf_depth(BUF_ADDR_BITS, DATA_BUF_OFFSET_WIDTH);
    localparam int OCC_W  = IDX_W + 1;
    localparam int DATA_W = BEATS * DATA_WIDTH;
`ifdef DDR4_MC_ECC_BUF_PARITY_EN
    localparam int RAM_W  = DATA_W + BEATS;
`else
    localparam int RAM_W  = DATA_W;
`endif

    // TCQ only matters to behavioural models of this block.
    logic w_unused_tcq;
    assign w_unused_tcq = (TCQ != 0);

    logic [IDX_W-1:0]  w_cap_idx, w_req_idx;
    logic [DATA_W-1:0] w_cap_data;
    logic [RAM_W-1:0]  w_wr_word, w_rd_word, w_sel_word;
    logic              w_same_idx, w_hit_wr, w_entry_vld, w_rel;
    logic              w_occ_inc, w_occ_dec, w_ovw;
    logic [DEPTH-1:0]  w_valid_nxt;

    logic [DEPTH-1:0]  r_valid;
    logic [OCC_W-1:0]  r_occ;
    logic [DATA_W-1:0] r_merge_data;
    logic              r_merge_valid, r_merge_miss, r_ovw_err;

    // The cast drops tag bits above BUF_ADDR_BITS or zero-extends a narrow address.
    assign w_cap_idx = {BUF_ADDR_BITS'(rd_data_addr), rd_data_offset};
    assign w_req_idx = {BUF_ADDR_BITS'(wr_data_addr), wr_data_offset};

    for (genvar h = 0; h < BEATS; h++) begin : g_beat
        assign w_cap_data[h*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(beat_extract(MAX_PAYLOAD_W'(rd_data), h, PAYLOAD_WIDTH));
    end

`ifdef DDR4_MC_ECC_BUF_PARITY_EN
    logic [BEATS-1:0] w_cap_par, w_chk_par, w_par_err;
    logic [BEATS-1:0] r_par_err;

    for (genvar h = 0; h < BEATS; h++) begin : g_par
        assign w_cap_par[h] = even_par(MAX_BEAT_W'(w_cap_data[h*DATA_WIDTH +: DATA_WIDTH]));
        assign w_chk_par[h] = even_par(MAX_BEAT_W'(w_sel_word[h*DATA_WIDTH +: DATA_WIDTH]));
    end

    assign w_wr_word = {w_cap_par, w_cap_data};
    assign w_par_err = w_sel_word[RAM_W-1 -: BEATS] ^ w_chk_par;
    assign rd_merge_par_err = r_par_err;
`else
    assign w_wr_word = w_cap_data;
`endif

    ddr4_mc_ecc_buf_ram #(
        .WIDTH  (RAM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (wr_ecc_buf),
        .i_waddr (w_cap_idx),
        .i_wdata (w_wr_word),
        .i_raddr (w_req_idx),
        .o_rdata (w_rd_word)
    );

    // Write-first: a same-cycle capture to the requested slot is returned directly.
    assign w_same_idx  = (w_cap_idx == w_req_idx);
    assign w_hit_wr    = wr_ecc_buf && w_same_idx;
    assign w_sel_word  = w_hit_wr ? w_wr_word : w_rd_word;
    assign w_entry_vld = w_hit_wr || r_valid[w_req_idx];
    assign w_rel       = rd_merge_req && rd_merge_release && r_valid[w_req_idx];

    assign w_occ_inc = wr_ecc_buf && !r_valid[w_cap_idx];
    assign w_occ_dec = w_rel && !w_hit_wr;
    assign w_ovw     = wr_ecc_buf && r_valid[w_cap_idx] && !(w_rel && w_same_idx);

    // Release is applied before capture so a same-slot capture keeps the entry valid.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_rel)      w_valid_nxt[w_req_idx] = 1'b0;
        if (wr_ecc_buf) w_valid_nxt[w_cap_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_occ         <= '0;
            r_merge_data  <= '0;
            r_merge_valid <= 1'b0;
            r_merge_miss  <= 1'b0;
            r_ovw_err     <= 1'b0;
        end else begin
            r_valid       <= w_valid_nxt;
            r_merge_valid <= rd_merge_req && w_entry_vld;
            r_merge_miss  <= rd_merge_req && !w_entry_vld;
            if (rd_merge_req && w_entry_vld) r_merge_data <= w_sel_word[DATA_W-1:0];
            if (w_ovw) r_ovw_err <= 1'b1;
            case ({w_occ_inc, w_occ_dec})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef DDR4_MC_ECC_BUF_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)                              r_par_err <= '0;
        else if (rd_merge_req && w_entry_vld) r_par_err <= w_par_err;
        else                                  r_par_err <= '0;
    end
`endif

    assign rd_merge_data     = r_merge_data;
    assign rd_merge_valid    = r_merge_valid;
    assign rd_merge_miss     = r_merge_miss;
    assign buf_occupancy     = r_occ;
    assign buf_overwrite_err = r_ovw_err;

endmodule

// File: tb/tb_ddr4_mc_ecc_merge_buf.sv
// Directed bench for ddr4_mc_ecc_merge_buf (default parameters, 32 entries, 8 beats of 64 bits).
`timescale 1ns/1ps
module tb_ddr4_mc_ecc_merge_buf;

    localparam int BEATS = 8;
    localparam int DW    = 64;
    localparam int PW    = 72;

    logic         clk = 1'b0;
    logic         rst;
    logic [575:0] rd_data;
    logic [4:0]   rd_data_addr, wr_data_addr;
    logic [0:0]   rd_data_offset, wr_data_offset;
    logic         wr_ecc_buf, rd_merge_req, rd_merge_release;
    logic [511:0] rd_merge_data;
    logic         rd_merge_valid, rd_merge_miss, buf_overwrite_err;
    logic [5:0]   buf_occupancy;
`ifdef DDR4_MC_ECC_BUF_PARITY_EN
    logic [7:0]   rd_merge_par_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr4_mc_ecc_merge_buf dut (
        .clk               (clk),
        .rst               (rst),
        .rd_data           (rd_data),
        .rd_data_addr      (rd_data_addr),
        .rd_data_offset    (rd_data_offset),
        .wr_ecc_buf        (wr_ecc_buf),
        .wr_data_addr      (wr_data_addr),
        .wr_data_offset    (wr_data_offset),
        .rd_merge_req      (rd_merge_req),
        .rd_merge_release  (rd_merge_release),
        .rd_merge_data     (rd_merge_data),
        .rd_merge_valid    (rd_merge_valid),
        .rd_merge_miss     (rd_merge_miss),
`ifdef DDR4_MC_ECC_BUF_PARITY_EN
        .rd_merge_par_err  (rd_merge_par_err),
`endif
        .buf_occupancy     (buf_occupancy),
        .buf_overwrite_err (buf_overwrite_err)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_val(input int seed, input int h);
        return {8'hA5 ^ 8'(seed), 8'(h), 16'(seed * 3), 32'h1357_9BDF + 32'(h)};
    endfunction

    function automatic logic [511:0] exp_data(input int seed);
        logic [511:0] d;
        for (int h = 0; h < BEATS; h++) d[h*DW +: DW] = beat_val(seed, h);
        return d;
    endfunction

    // Interleave stored beats with random ECC bytes.
    function automatic logic [575:0] pay_from(input logic [511:0] d);
        logic [575:0] p;
        for (int h = 0; h < BEATS; h++) begin
            p[h*PW +: DW]     = d[h*DW +: DW];
            p[h*PW + DW +: 8] = 8'($urandom);
        end
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_ecc_buf       = 1'b0;
        rd_merge_req     = 1'b0;
        rd_merge_release = 1'b0;
    endtask

    // Tag bit (addr[4]) set to 1 on captures to show it is ignored.
    task automatic cap(input int idx, input logic [575:0] p);
        wr_ecc_buf     = 1'b1;
        rd_data        = p;
        rd_data_addr   = {1'b1, 4'(idx >> 1)};
        rd_data_offset = 1'(idx);
    endtask

    task automatic req(input int idx, input logic rel);
        rd_merge_req     = 1'b1;
        rd_merge_release = rel;
        wr_data_addr     = {1'b0, 4'(idx >> 1)};
        wr_data_offset   = 1'(idx);
    endtask

    logic [511:0] d2;
`ifdef DDR4_MC_ECC_BUF_PARITY_EN
    logic [575:0] ram_word;
`endif

    initial begin
        rst = 1'b1;
        rd_data = '0; rd_data_addr = '0; rd_data_offset = '0;
        wr_data_addr = '0; wr_data_offset = '0;
        idle();
        tick(); tick();
        chk("rst_occ", buf_occupancy, 0);
        chk("rst_valid", rd_merge_valid, 0);
        chk("rst_miss", rd_merge_miss, 0);
        chk("rst_data", rd_merge_data, 0);
        chk("rst_ovw", buf_overwrite_err, 0);
        rst = 1'b0;

        // miss on empty buffer
        req(3, 1'b0); tick(); idle();
        chk("miss3_miss", rd_merge_miss, 1);
        chk("miss3_valid", rd_merge_valid, 0);
        chk("miss3_occ", buf_occupancy, 0);
        tick();
        chk("miss3_pulse", rd_merge_miss, 0);

        // capture addr 5 / off 1 (idx 11), read two cycles later
        for (int h = 0; h < BEATS; h++) d2[h*DW +: DW] = 64'hA5A5_0000_0000_0000 | 64'(h);
        cap(11, pay_from(d2)); tick(); idle(); tick();
        req(11, 1'b0); tick(); idle();
        chk("rd11_valid", rd_merge_valid, 1);
        chk("rd11_data", rd_merge_data, d2);
        chk("rd11_occ", buf_occupancy, 1);
        tick();
        chk("rd11_vpulse", rd_merge_valid, 0);
        chk("rd11_hold", rd_merge_data, d2);
        req(11, 1'b1); tick(); idle();
        chk("rel11_valid", rd_merge_valid, 1);
        chk("rel11_occ", buf_occupancy, 0);
        req(11, 1'b0); tick(); idle();
        chk("rel11_miss", rd_merge_miss, 1);
        chk("miss_hold", rd_merge_data, d2);

        // bypass with release on idx 7: capture wins
        cap(7, pay_from(exp_data(7))); req(7, 1'b1); tick(); idle();
        chk("byp7_valid", rd_merge_valid, 1);
        chk("byp7_data", rd_merge_data, exp_data(7));
        chk("byp7_occ", buf_occupancy, 1);
        req(7, 1'b0); tick(); idle();
        chk("byp7_still", rd_merge_valid, 1);
        req(7, 1'b1); tick(); idle();
        chk("byp7_relocc", buf_occupancy, 0);

        // fill all 32, drain with back-to-back release requests
        for (int i = 0; i < 32; i++) begin
            cap(i, pay_from(exp_data(i + 100))); tick();
        end
        idle();
        chk("fill_occ", buf_occupancy, 32);
        for (int i = 0; i < 32; i++) begin
            req(i, 1'b1); tick();
            chk($sformatf("drain%0d_valid", i), rd_merge_valid, 1);
            chk($sformatf("drain%0d_miss", i), rd_merge_miss, 0);
            chk($sformatf("drain%0d_data", i), rd_merge_data, exp_data(i + 100));
            chk($sformatf("drain%0d_occ", i), buf_occupancy, 512'(31 - i));
        end
        idle(); tick();
        chk("drain_end_valid", rd_merge_valid, 0);

        // overwrite error on idx 2
        cap(2, pay_from(exp_data(2))); tick();
        chk("ovw_first", buf_overwrite_err, 0);
        chk("ovw_occ1", buf_occupancy, 1);
        cap(2, pay_from(exp_data(3))); tick(); idle();
        chk("ovw_set", buf_overwrite_err, 1);
        chk("ovw_occ", buf_occupancy, 1);
        req(2, 1'b0); tick(); idle();
        chk("ovw_data", rd_merge_data, exp_data(3));
        // release without request is ignored
        rd_merge_release = 1'b1; wr_data_addr = 5'd1; wr_data_offset = 1'b0; tick(); idle();
        chk("relonly_occ", buf_occupancy, 1);
        // capture idx 4 while releasing idx 2: occupancy unchanged
        cap(4, pay_from(exp_data(4))); req(2, 1'b1); tick(); idle();
        chk("swap_valid", rd_merge_valid, 1);
        chk("swap_data", rd_merge_data, exp_data(3));
        chk("swap_occ", buf_occupancy, 1);
        // release of an invalid entry
        req(9, 1'b1); tick(); idle();
        chk("relinv_miss", rd_merge_miss, 1);
        chk("relinv_occ", buf_occupancy, 1);
        chk("ovw_sticky", buf_overwrite_err, 1);

        // reset with a request in flight
        req(4, 1'b0); rst = 1'b1; tick(); idle(); rst = 1'b0;
        chk("rrst_valid", rd_merge_valid, 0);
        chk("rrst_miss", rd_merge_miss, 0);
        chk("rrst_ovw", buf_overwrite_err, 0);
        chk("rrst_occ", buf_occupancy, 0);
        chk("rrst_data", rd_merge_data, 0);
        tick();
        chk("rrst_nopulse", rd_merge_valid, 0);
        req(4, 1'b0); tick(); idle();
        chk("rrst_cleared", rd_merge_miss, 1);

`ifdef DDR4_MC_ECC_BUF_PARITY_EN
        cap(12, pay_from(exp_data(12))); tick(); idle();
        req(12, 1'b0); tick(); idle();
        chk("par_clean", rd_merge_par_err, 0);
        chk("par_clean_v", rd_merge_valid, 1);
        ram_word = 576'(dut.u_ram.r_mem[12]);
        ram_word[4*DW + 3] = ~ram_word[4*DW + 3];
        dut.u_ram.r_mem[12] = ram_word[519:0];
        req(12, 1'b0); tick(); idle();
        chk("par_err", rd_merge_par_err, 8'h10);
        chk("par_err_v", rd_merge_valid, 1);
        req(13, 1'b0); tick(); idle();
        chk("par_miss", rd_merge_par_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
